// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller.
// Event codes to CP0, CP0 register addresses, default vector, FSM states.
// Also holds the interrupt-pending helper used by the arbiter.
package exception_ctrl_pkg;

  // Event codes presented to CP0 (Cause.ExcCode style encoding)
  localparam logic [3:0] EXC_NONE    = 4'h0;
  localparam logic [3:0] EXC_INT     = 4'h1;
  localparam logic [3:0] EXC_RI      = 4'h8;
  localparam logic [3:0] EXC_SYSCALL = 4'ha;
  localparam logic [3:0] EXC_TRAP    = 4'hd;
  localparam logic [3:0] EXC_ERET    = 4'he;

  // CP0 register addresses
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Redirect target for every event except ERET
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_e;

  // IE set, EXL clear, and at least one unmasked pending line
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
  endfunction

endpackage

// File: rtl/exception_ctrl_exc_prio_enc.sv
// Fixed-priority encoder: interrupt > RI > SYSCALL > TRAP > ERET.
// Purely combinational, zero latency.
// No backpressure; en low forces EXC_NONE.
// Ports: en, int_pending, ri, syscall, trap, eret -> execode (4 bits).
module exc_prio_enc
  import exception_ctrl_pkg::*;
(
  input  logic       en,
  input  logic       int_pending,
  input  logic       ri,
  input  logic       syscall,
  input  logic       trap,
  input  logic       eret,
  output logic [3:0] execode
);

  always_comb begin
    execode = EXC_NONE;
    if (en) begin
      if (int_pending)  execode = EXC_INT;
      else if (ri)      execode = EXC_RI;
      else if (syscall) execode = EXC_SYSCALL;
      else if (trap)    execode = EXC_TRAP;
      else if (eret)    execode = EXC_ERET;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: picks one event, reports it to CP0, then flushes and redirects.
// Latency: execode_o/current_pc_o combinational in T; flush_o/new_pc_o registered for T+1..T+FLUSH_CYCLES.
// Backpressure: while flushing, all MEM inputs are ignored; arbitration resumes once back in IDLE.
// Ports: clk, rst (async active-low), mem_* event flags and PC, cp0_* Status/Cause/EPC,
//        wb_cp0_* MTC0 write; outputs execode_o, current_pc_o, flush_o, new_pc_o.
// Optional macro EXC_CP0_FWD_EN: forward a same-cycle WB MTC0 to Status/EPC.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_exc_ri_i,
  input  logic        mem_exc_syscall_i,
  input  logic        mem_exc_trap_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [3:0]  execode_o,
  output logic [31:0] current_pc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  exc_state_e  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] new_pc_q, new_pc_nxt;
  logic [31:0] status_eff, epc_eff;
  logic        int_pend, arb_en;
  logic [3:0]  execode;

`ifdef EXC_CP0_FWD_EN
  // An MTC0 retiring in WB this cycle is not yet visible in CP0; take it directly.
  always_comb begin
    status_eff = cp0_status_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS) status_eff = wb_cp0_wdata_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_EPC)    epc_eff    = wb_cp0_wdata_i;
  end
`else
  assign status_eff = cp0_status_i;
  assign epc_eff    = cp0_epc_i;
  logic unused_wb;
  assign unused_wb = ^{wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i};
`endif

  assign int_pend = int_pending(status_eff, cp0_cause_i);

  // rst gates the combinational code so CP0 sees nothing while reset is held.
  assign arb_en = (state == ST_IDLE) && mem_valid_i && rst;

  exc_prio_enc u_prio (
    .en          (arb_en),
    .int_pending (int_pend),
    .ri          (mem_exc_ri_i),
    .syscall     (mem_exc_syscall_i),
    .trap        (mem_exc_trap_i),
    .eret        (mem_eret_i),
    .execode     (execode)
  );

  assign execode_o    = execode;
  assign current_pc_o = (execode != EXC_NONE) ? mem_pc_i : 32'h0;
  assign flush_o      = (state == ST_FLUSH);
  assign new_pc_o     = new_pc_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    new_pc_nxt = new_pc_q;
    case (state)
      ST_IDLE: begin
        if (execode != EXC_NONE) begin
          state_nxt  = ST_FLUSH;
          cnt_nxt    = 4'(FLUSH_CYCLES - 1);
          new_pc_nxt = (execode == EXC_ERET) ? epc_eff : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        // Leave on the edge after the counter has reached zero
        if (cnt == 4'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      new_pc_q <= 32'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      new_pc_q <= new_pc_nxt;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: default instance (FLUSH_CYCLES=2) plus a FLUSH_CYCLES=1 instance.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_pc_i = '0;
  logic        mem_exc_ri_i = 1'b0, mem_exc_syscall_i = 1'b0, mem_exc_trap_i = 1'b0, mem_eret_i = 1'b0;
  logic [31:0] cp0_status_i = '0, cp0_cause_i = '0, cp0_epc_i = '0;
  logic        wb_cp0_we_i = 1'b0;
  logic [4:0]  wb_cp0_waddr_i = '0;
  logic [31:0] wb_cp0_wdata_i = '0;

  logic [3:0]  execode_o, execode1;
  logic [31:0] current_pc_o, current_pc1, new_pc_o, new_pc1;
  logic        flush_o, flush1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_exc_ri_i(mem_exc_ri_i), .mem_exc_syscall_i(mem_exc_syscall_i),
    .mem_exc_trap_i(mem_exc_trap_i), .mem_eret_i(mem_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .execode_o(execode_o), .current_pc_o(current_pc_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  exception_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_exc_ri_i(mem_exc_ri_i), .mem_exc_syscall_i(mem_exc_syscall_i),
    .mem_exc_trap_i(mem_exc_trap_i), .mem_eret_i(mem_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .execode_o(execode1), .current_pc_o(current_pc1), .flush_o(flush1), .new_pc_o(new_pc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_mem();
    mem_valid_i = 1'b0; mem_pc_i = '0;
    mem_exc_ri_i = 1'b0; mem_exc_syscall_i = 1'b0; mem_exc_trap_i = 1'b0; mem_eret_i = 1'b0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = '0; wb_cp0_wdata_i = '0;
  endtask

  // Advance to the next falling edge; caller then drives and waits #1 before checking
  task automatic nxt();
    @(negedge clk);
  endtask

  // Let any flush in progress drain with MEM idle
  task automatic drain();
    clr_mem();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset state
    nxt(); #1;
    chk("rst_execode", 32'(execode_o), 32'h0);
    chk("rst_cur_pc", current_pc_o, 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_new_pc", new_pc_o, 32'h0);
    nxt(); rst = 1'b1;

    // RI at 0x100: report in T, flush T+1..T+2, idle T+3
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h100; mem_exc_ri_i = 1'b1; #1;
    chk("ri_execode", 32'(execode_o), 32'h8);
    chk("ri_cur_pc", current_pc_o, 32'h100);
    chk("ri_flush_T", 32'(flush_o), 32'h0);
    nxt(); clr_mem(); #1;
    chk("ri_flush_T1", 32'(flush_o), 32'h1);
    chk("ri_new_pc_T1", new_pc_o, 32'h20);
    chk("ri_execode_T1", 32'(execode_o), 32'h0);
    chk("ri1_flush_T1", 32'(flush1), 32'h1);
    nxt(); #1;
    chk("ri_flush_T2", 32'(flush_o), 32'h1);
    chk("ri_new_pc_T2", new_pc_o, 32'h20);
    chk("ri1_flush_T2", 32'(flush1), 32'h0);
    nxt(); #1;
    chk("ri_flush_T3", 32'(flush_o), 32'h0);
    drain();

    // Interrupt beats RI
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h200; mem_exc_ri_i = 1'b1;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400; #1;
    chk("int_execode", 32'(execode_o), 32'h1);
    chk("int_cur_pc", current_pc_o, 32'h200);
    drain();

    // EXL set: interrupt masked, RI taken
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h204; mem_exc_ri_i = 1'b1;
    cp0_status_i = 32'h0000_0403; #1;
    chk("exl_execode", 32'(execode_o), 32'h8);
    drain();

    // IM bit for the pending line clear: nothing taken
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h208; cp0_status_i = 32'h0000_0001; #1;
    chk("im_masked_execode", 32'(execode_o), 32'h0);
    chk("im_masked_cur_pc", current_pc_o, 32'h0);
    drain();

    // Trap beats ERET
    cp0_status_i = '0; cp0_cause_i = '0;
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h20c; mem_exc_trap_i = 1'b1; mem_eret_i = 1'b1; #1;
    chk("trap_execode", 32'(execode_o), 32'hd);
    drain();

    // ERET with same-cycle MTC0 EPC
    cp0_epc_i = 32'h40;
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h210; mem_eret_i = 1'b1;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h80; #1;
    chk("eret_execode", 32'(execode_o), 32'he);
    chk("eret_cur_pc", current_pc_o, 32'h210);
    nxt(); clr_mem(); #1;
    chk("eret_flush", 32'(flush_o), 32'h1);
`ifdef EXC_CP0_FWD_EN
    chk("eret_new_pc", new_pc_o, 32'h80);
`else
    chk("eret_new_pc", new_pc_o, 32'h40);
`endif
    drain();

    // Same-cycle MTC0 Status clearing IE
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h214;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h0000_0400; #1;
`ifdef EXC_CP0_FWD_EN
    chk("ie_fwd_execode", 32'(execode_o), 32'h0);
`else
    chk("ie_fwd_execode", 32'(execode_o), 32'h1);
`endif
    drain();
    cp0_status_i = '0; cp0_cause_i = '0;

    // Back-to-back SYSCALLs held in MEM
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h300; mem_exc_syscall_i = 1'b1; #1;
    chk("sys_T_execode", 32'(execode_o), 32'ha);
    nxt(); mem_pc_i = 32'h304; #1;
    chk("sys_T1_execode", 32'(execode_o), 32'h0);
    chk("sys_T1_cur_pc", current_pc_o, 32'h0);
    nxt(); #1;
    chk("sys_T2_execode", 32'(execode_o), 32'h0);
    nxt(); #1;
    chk("sys_T3_execode", 32'(execode_o), 32'ha);
    chk("sys_T3_cur_pc", current_pc_o, 32'h304);
    chk("sys_T3_flush", 32'(flush_o), 32'h0);
    drain();

    // mem_valid_i low with every flag set
    nxt(); mem_pc_i = 32'h400; mem_exc_ri_i = 1'b1; mem_exc_syscall_i = 1'b1;
    mem_exc_trap_i = 1'b1; mem_eret_i = 1'b1;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400; #1;
    chk("novalid_execode", 32'(execode_o), 32'h0);
    chk("novalid_cur_pc", current_pc_o, 32'h0);
    nxt(); #1;
    chk("novalid_flush", 32'(flush_o), 32'h0);
    drain();
    cp0_status_i = '0; cp0_cause_i = '0;

    // Reset asserted mid-flush
    nxt(); mem_valid_i = 1'b1; mem_pc_i = 32'h500; mem_exc_ri_i = 1'b1;
    nxt(); #1;
    chk("mid_flush_pre", 32'(flush_o), 32'h1);
    rst = 1'b0; #1;
    chk("mid_rst_flush", 32'(flush_o), 32'h0);
    chk("mid_rst_new_pc", new_pc_o, 32'h0);
    chk("mid_rst_execode", 32'(execode_o), 32'h0);
    clr_mem();
    nxt(); rst = 1'b1;
    nxt(); #1;
    chk("post_rst_flush", 32'(flush_o), 32'h0);
    nxt(); #1;
    chk("post_rst_flush2", 32'(flush_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
